// File: rtl/pwm_reg_ctrl.sv
// Register controller for the PWM array: decodes framed SPI bytes into register
// accesses and moves shadow duty values to the active set at each channel's period end.
module pwm_reg_ctrl #(
  parameter int          PWM_INSTANCES = 1,
  parameter logic [7:0]  ID_VALUE      = 8'hA5
) (
  input  logic                         clk_i,
  input  logic                         nrst_i,
  input  logic                         frame_start_i,
  input  logic                         byte_valid_i,
  input  logic [7:0]                   byte_i,
  output logic [7:0]                   tx_byte_o,
  output logic                         tx_load_o,
  input  logic [PWM_INSTANCES-1:0]     period_end_i,
  output logic                         enable_o,
  output logic [8*PWM_INSTANCES-1:0]   duty_o,
  output logic                         busy_o
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t                       state_q, state_d;
  logic                         rw_q, rw_d;
  logic [6:0]                   addr_q, addr_d;
  logic [7:0]                   tx_byte_q, tx_byte_d;
  logic                         tx_load_q, tx_load_d;
  logic                         enable_q, enable_d;
  logic                         busy_q, busy_d;
  logic [PWM_INSTANCES-1:0]     pending_q, pending_d;
  logic [8*PWM_INSTANCES-1:0]   shadow_q, shadow_d;
  logic [8*PWM_INSTANCES-1:0]   active_q, active_d;
  logic [7:0]                   rd_data;
  logic                         wr_en;

  // Read data is decoded straight from the command byte so it can be loaded
  // into the shifter on the same edge that accepts the command.
  always_comb begin
    rd_data = 8'h00;
    if (byte_i[6:0] == 7'h00) begin
      rd_data = {busy_q, 6'b000000, enable_q};
    end else if (byte_i[6:0] == 7'h7F) begin
      rd_data = ID_VALUE;
    end
    for (int k = 0; k < PWM_INSTANCES; k++) begin
      if (int'(byte_i[6:0]) == k + 1) begin
        rd_data = shadow_q[8*k +: 8];
      end
      if (int'(byte_i[6:0]) == k + 64) begin
        rd_data = active_q[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    tx_byte_d = tx_byte_q;
    tx_load_d = 1'b0;
    enable_d  = enable_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    busy_d    = |pending_q;
    wr_en     = 1'b0;

    if (frame_start_i) begin
      state_d = CMD;
    end else begin
      case (state_q)
        CMD: begin
          if (byte_valid_i) begin
            rw_d    = byte_i[7];
            addr_d  = byte_i[6:0];
            state_d = DATA;
            if (byte_i[7]) begin
              tx_byte_d = rd_data;
              tx_load_d = 1'b1;
            end
          end
        end
        DATA: begin
          if (byte_valid_i) begin
            wr_en   = ~rw_q;
            state_d = DONE;
          end
        end
        default: state_d = state_q;
      endcase
    end

    // Transfers use the registered enable, so a 0x81 write waits for period ends.
    for (int k = 0; k < PWM_INSTANCES; k++) begin
      if (pending_q[k] && (period_end_i[k] || !enable_q)) begin
        active_d[8*k +: 8] = shadow_q[8*k +: 8];
        pending_d[k]       = 1'b0;
      end
    end

    // Register writes come after the transfer so a fresh commit always re-arms.
    if (wr_en) begin
      if (addr_q == 7'h00) begin
        enable_d = byte_i[0];
        if (byte_i[7]) begin
          pending_d = '1;
        end
      end
      for (int k = 0; k < PWM_INSTANCES; k++) begin
        if (int'(addr_q) == k + 1) begin
          shadow_d[8*k +: 8] = byte_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      state_q   <= IDLE;
      rw_q      <= 1'b0;
      addr_q    <= 7'h00;
      tx_byte_q <= 8'h00;
      tx_load_q <= 1'b0;
      enable_q  <= 1'b0;
      busy_q    <= 1'b0;
      pending_q <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
    end else begin
      state_q   <= state_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      tx_byte_q <= tx_byte_d;
      tx_load_q <= tx_load_d;
      enable_q  <= enable_d;
      busy_q    <= busy_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
    end
  end

  assign tx_byte_o = tx_byte_q;
  assign tx_load_o = tx_load_q;
  assign enable_o  = enable_q;
  assign duty_o    = active_q;
  assign busy_o    = busy_q;

endmodule

// File: doc/pwm_reg_ctrl.md
# pwm_reg_ctrl

Register controller and update scheduler between the SPI byte interface and the PWM channel array of `pwm_controller_top`. It decodes framed SPI byte streams into register reads and writes, and holds per-channel shadow duty registers. It schedules shadow-to-active duty transfers so that each channel updates only at its own period boundary, with no glitched periods.

## Interface
- `PWM_INSTANCES`, 1: number of PWM channels, 1..16.
- `ID_VALUE`, 8'hA5: constant returned by the ID register.

- `clk_i`  in  1  system clock; all logic on the rising edge.
- `nrst_i`  in  1  synchronous, active-low reset.
- `frame_start_i`  in  1  one-cycle pulse when SPI nCS falls (already synchronised to `clk_i`).
- `byte_valid_i`  in  1  one-cycle pulse: `byte_i` holds a complete received byte.
- `byte_i`  in  8  received byte, MSB first on the wire.
- `tx_byte_o`  out  8  byte for the SPI shifter to transmit.
- `tx_load_o`  out  1  one-cycle pulse: shifter loads `tx_byte_o`.
- `period_end_i`  in  PWM_INSTANCES  per-channel one-cycle pulse on the last clock of each PWM period.
- `enable_o`  out  1  global PWM enable (CTRL bit 0).
- `duty_o`  out  8*PWM_INSTANCES  active duty values; channel k is bits [8k+7:8k].
- `busy_o`  out  1  high while any channel has a commit pending.

## Operation
- Frame format:
  - Byte 0 is the command: bit 7 = read (1) or write (0); bits 6:0 = address.
  - Byte 1 is the write data, or a dummy byte on a read.
  - Bytes after byte 1 are ignored until the next `frame_start_i`.
- FSM states: IDLE, CMD, DATA, DONE.
  - Reset leads to IDLE.
  - `frame_start_i` leads to CMD from any state, which aborts any partial frame.
  - CMD + `byte_valid_i`: latch the address and R/W bit, then go to DATA.
  - DATA + `byte_valid_i`: on a write, perform the register write; on a read, discard the byte. Then go to DONE.
  - IDLE and DONE ignore `byte_valid_i`.
- Register map:
  - 0x00 CTRL:
    - bit 0 = ENABLE, read/write, takes effect immediately.
    - bit 7 = COMMIT, write-1 sets the pending bit for every channel. Reads as `busy_o`.
    - bits 6:1 read 0.
  - 0x01..0x00+PWM_INSTANCES: SHADOW_DUTY[k], read/write.
  - 0x40..0x3F+PWM_INSTANCES: ACTIVE_DUTY[k], read-only; writes are ignored.
  - 0x7F: ID, read-only, returns `ID_VALUE`.
  - Any other address: writes ignored, reads return 0x00.
- Commit scheduling, per channel k:
  - A commit sets pending[k].
  - When pending[k] is set and `period_end_i[k]` is high, ACTIVE_DUTY[k] takes the current SHADOW_DUTY[k] and pending[k] clears.
  - When ENABLE = 0, all pending transfers complete on the next clock, regardless of `period_end_i`.
- Boundary cases:
  - A commit written while already pending keeps the channel pending; there is no double transfer.
  - A shadow write while pending: the transfer uses the value present at the transfer cycle.
  - A COMMIT write in the same cycle as `period_end_i[k]`: the transfer does not happen in that cycle; it waits for the next period end.
  - A CTRL write with bit 7 = 0 leaves the pending bits unchanged.
  - A write of 0x81 to CTRL sets ENABLE and COMMIT in the same cycle. The pending bits then wait for period ends, because ENABLE is already 1 in the cycle after the write.

## Timing
- Reset values:
  - All outputs: `tx_byte_o` = 0x00, `tx_load_o` = 0, `enable_o` = 0, `duty_o` = 0, `busy_o` = 0.
  - All shadow registers, active registers and pending bits = 0.
  - FSM = IDLE.
  - Reset mid-frame aborts the frame; the frame is not resumed.
- Write latency: the register changes on the edge that samples the data byte's `byte_valid_i`, so it is visible on outputs one cycle later.
- Read latency:
  - `tx_load_o` pulses exactly one cycle after the command byte's `byte_valid_i`.
  - The register value is sampled at that point and is valid on `tx_byte_o` in the same cycle as the pulse.
  - `tx_byte_o` holds its value until the next load.
- Commit transfer: `duty_o[k]` changes the cycle after the qualifying `period_end_i[k]`.
- `busy_o` is registered and equals the OR of the pending bits, one cycle after they change.
- A `frame_start_i` and a `byte_valid_i` in the same cycle: `frame_start_i` wins and the byte is dropped.

## Test plan
- Reset, then read 0x7F → `tx_load_o` one cycle after the command byte, `tx_byte_o` = 0xA5.
- Write 0x01 = 0x01, then CTRL = 0x81 → `enable_o` = 1, `busy_o` = 1, `duty_o` stays 0x00. Pulse `period_end_i[0]` → `duty_o` = 0x01 the next cycle, `busy_o` = 0. Read CTRL → 0x01.
- With ENABLE = 0: write 0x01 = 0x40, then CTRL = 0x80 → `duty_o` = 0x40 within 2 cycles, with no `period_end_i` pulse.
- Commit pending, then write 0x01 = 0x22 before the period end → the transfer applies 0x22. COMMIT written in the same cycle as `period_end_i` → no transfer until the next pulse.
- Send the command byte for write 0x01, then `frame_start_i`, then a full write frame 0x01 = 0x33 → shadow = 0x33, with no spurious write. Send three bytes in one frame → the third byte is ignored.
- Write 0x40 = 0xFF and 0x20 = 0x12 → no register changes. Read 0x20 → 0x00. Assert `nrst_i` mid-frame → all outputs return to their reset values.
